// File: rtl/memarb.sv
// Round-robin arbiter sharing one tsdram command port between NREQ cache-bus requesters.
// Latches the winner's command until cmd_ack and steers read-data strobes back to the reader.
module memarb #(
    parameter int NREQ  = 3,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*NREQ-1:0]    req_i,
    input  logic [2*NREQ-1:0]    mask_i,
    input  logic [26*NREQ-1:0]   addr_i,
    input  logic [16*NREQ-1:0]   wdata_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      dvalid_o,
    output logic [1:0]           cmd_req,
    output logic [1:0]           cmd_mask,
    output logic [25:0]          cmd_addr,
    output logic [15:0]          cmd_din,
    input  logic                 cmd_ack,
    input  logic                 data_valid,
    output logic                 rd_err
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [IW-1:0]   rd_owner;
    logic [IW-1:0]   pick;
    logic            found;
    logic            rd_busy;
    logic [CW-1:0]   rd_cnt;
    logic [NREQ-1:0] elig;
    int unsigned     idx;

    // A line read cannot be issued while another read's data is still returning.
    always_comb begin
        elig = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            elig[k] = (req_i[2*k +: 2] == 2'b01) ||
                      ((req_i[2*k +: 2] == 2'b10) && !rd_busy);
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        dvalid_o = '0;
        if (data_valid && rd_busy) begin
            dvalid_o[rd_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cmd_req  <= '0;
            cmd_mask <= '0;
            cmd_addr <= '0;
            cmd_din  <= '0;
            ack_o    <= '0;
            rd_err   <= 1'b0;
            owner    <= '0;
            last     <= IW'(NREQ - 1);
            rd_owner <= '0;
            rd_busy  <= 1'b0;
            rd_cnt   <= '0;
        end else begin
            if (data_valid) begin
                if (rd_busy) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == CW'(BURST - 1)) begin
                        rd_busy <= 1'b0;
                    end
                end else begin
                    rd_err <= 1'b1;
                end
            end

            // Read tracking on cmd_ack is assigned after the data_valid update so a new read wins.
            case (state)
                S_IDLE: begin
                    if (found) begin
                        cmd_req  <= req_i[2*pick +: 2];
                        cmd_mask <= mask_i[2*pick +: 2];
                        cmd_din  <= wdata_i[16*pick +: 16];
                        if (req_i[2*pick +: 2] == 2'b10) begin
                            cmd_addr <= {addr_i[26*pick+3 +: 23], 3'b000};
                        end else begin
                            cmd_addr <= addr_i[26*pick +: 26];
                        end
                        owner <= pick;
                        last  <= pick;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmd_ack) begin
                        cmd_req      <= '0;
                        ack_o[owner] <= 1'b1;
                        state        <= S_END;
                        if (cmd_req == 2'b10) begin
                            rd_busy  <= 1'b1;
                            rd_owner <= owner;
                            rd_cnt   <= '0;
                        end
                    end
                end
                S_END: begin
                    ack_o <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    ack_o   <= '0;
                    cmd_req <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memarb.sv
// Randomized and directed bench for memarb (NREQ=3, BURST=4) against a transaction-level model.
module tb_memarb;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  req_i, mask_i;
    logic [77:0] addr_i;
    logic [47:0] wdata_i;
    logic [2:0]  ack_o, dvalid_o;
    logic [1:0]  cmd_req, cmd_mask;
    logic [25:0] cmd_addr;
    logic [15:0] cmd_din;
    logic        cmd_ack, data_valid, rd_err;

    logic [1:0]  pc [3];
    logic [1:0]  pm [3];
    logic [25:0] pa [3];
    logic [15:0] pd [3];

    int passed = 0;
    int total  = 0;
    int  last_m;
    bit  busy_m;
    int  rd_owner_m;
    int  rd_left_m;

    assign req_i   = {pc[2], pc[1], pc[0]};
    assign mask_i  = {pm[2], pm[1], pm[0]};
    assign addr_i  = {pa[2], pa[1], pa[0]};
    assign wdata_i = {pd[2], pd[1], pd[0]};

    memarb #(.NREQ(3), .BURST(4)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .mask_i(mask_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .ack_o(ack_o), .dvalid_o(dvalid_o), .cmd_req(cmd_req),
        .cmd_mask(cmd_mask), .cmd_addr(cmd_addr), .cmd_din(cmd_din), .cmd_ack(cmd_ack),
        .data_valid(data_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    // Round-robin rule: first eligible port after the last winner, reads blocked while one is in flight.
    function automatic int predict(input int lst, input bit busy);
        int k;
        for (int i = 1; i <= 3; i++) begin
            k = (lst + i) % 3;
            if (pc[k] == 2'b01 || (pc[k] == 2'b10 && !busy)) return k;
        end
        return -1;
    endfunction

    function automatic logic [25:0] exp_addr(input int k);
        logic [25:0] a;
        a = pa[k];
        if (pc[k] == 2'b10) a[2:0] = 3'b000;
        return a;
    endfunction

    task automatic clear_ports();
        for (int k = 0; k < 3; k++) begin
            pc[k] = 2'b00; pm[k] = 2'b00; pa[k] = '0; pd[k] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; cmd_ack = 1'b0; data_valid = 1'b0;
        clear_ports();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        last_m = 2; busy_m = 0; rd_left_m = 0; rd_owner_m = 0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (cmd_req !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_now();
        cmd_ack = 1'b1;
        @(posedge clk); #1;
        cmd_ack = 1'b0;
    endtask

    task automatic pulse_dv(output logic [2:0] seen);
        @(posedge clk); #1 data_valid = 1'b1;
        #1 seen = dvalid_o;
        @(posedge clk); #1 data_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({cmd_req, cmd_mask, cmd_addr, cmd_din, ack_o, dvalid_o, rd_err} !== '0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {cmd_req, cmd_mask, cmd_addr, cmd_din, ack_o, dvalid_o, rd_err});
        else passed++;
        repeat (3) @(posedge clk); #1;
        total++;
        if (cmd_req !== 2'b00) $display("FAIL reset_idle_req: got %b expected 00", cmd_req);
        else passed++;
    endtask

    task automatic test_single_write();
        bit ok;
        pc[1] = 2'b01; pm[1] = 2'b11; pa[1] = 26'h0123457; pd[1] = 16'hBEEF;
        wait_grant(ok);
        total++;
        if (!ok) $display("FAIL single_grant: got no grant expected grant");
        else passed++;
        total++;
        if ({cmd_req, cmd_mask, cmd_addr, cmd_din} !== {2'b01, 2'b11, 26'h0123457, 16'hBEEF})
            $display("FAIL single_cmd: got %b %b %h %h expected 01 11 0123457 beef",
                     cmd_req, cmd_mask, cmd_addr, cmd_din);
        else passed++;
        repeat (2) @(posedge clk); #1;
        total++;
        if ({cmd_req, cmd_addr} !== {2'b01, 26'h0123457})
            $display("FAIL single_hold: got %b %h expected 01 0123457", cmd_req, cmd_addr);
        else passed++;
        ack_now();
        pc[1] = 2'b00;
        total++;
        if ({ack_o, cmd_req} !== {3'b010, 2'b00})
            $display("FAIL single_ack: got %b %b expected 010 00", ack_o, cmd_req);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (ack_o !== 3'b000) $display("FAIL single_ack_len: got %b expected 000", ack_o);
        else passed++;
        last_m = 1;
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pc[k] = 2'b01; pa[k] = 26'(32'h0100000 * (k + 1) + k); pd[k] = 16'(16'h1111 * (k + 1));
        end
        for (int n = 0; n < 6; n++) begin
            wait_grant(ok);
            total++;
            if (!ok || cmd_addr !== pa[n % 3] || cmd_din !== pd[n % 3])
                $display("FAIL rr_order_%0d: got %h %h expected %h %h", n, cmd_addr, cmd_din,
                         pa[n % 3], pd[n % 3]);
            else passed++;
            ack_now();
            total++;
            if (ack_o !== 3'(1 << (n % 3)))
                $display("FAIL rr_ack_%0d: got %b expected %b", n, ack_o, 3'(1 << (n % 3)));
            else passed++;
            last_m = n % 3;
        end
        clear_ports();
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        bit ok;
        logic [2:0] seen;
        pc[0] = 2'b10; pa[0] = 26'h0000105;
        wait_grant(ok);
        total++;
        if (!ok || cmd_req !== 2'b10 || cmd_addr !== 26'h0000100)
            $display("FAIL read_cmd: got %b %h expected 10 0000100", cmd_req, cmd_addr);
        else passed++;
        ack_now();
        pc[0] = 2'b00;
        total++;
        if (ack_o !== 3'b001) $display("FAIL read_ack: got %b expected 001", ack_o);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            pulse_dv(seen);
            total++;
            if (seen !== 3'b001) $display("FAIL read_dvalid_%0d: got %b expected 001", i, seen);
            else passed++;
        end
        total++;
        if (rd_err !== 1'b0) $display("FAIL read_no_err: got %b expected 0", rd_err);
        else passed++;
        last_m = 0;
    endtask

    task automatic test_read_block();
        bit ok;
        logic [2:0] seen;
        pc[0] = 2'b10; pa[0] = 26'h0000208;
        wait_grant(ok);
        ack_now();
        pc[0] = 2'b00;
        pc[1] = 2'b10; pa[1] = 26'h2ABCDEF; pd[1] = 16'h0001;
        pc[2] = 2'b01; pa[2] = 26'h1234567; pd[2] = 16'hCAFE;
        wait_grant(ok);
        total++;
        if (!ok || cmd_req !== 2'b01 || cmd_addr !== 26'h1234567)
            $display("FAIL block_write_first: got %b %h expected 01 1234567", cmd_req, cmd_addr);
        else passed++;
        ack_now();
        pc[2] = 2'b00;
        total++;
        if (ack_o !== 3'b100) $display("FAIL block_ack2: got %b expected 100", ack_o);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            pulse_dv(seen);
            @(posedge clk); #1;
            total++;
            if (seen !== 3'b001 || cmd_req !== 2'b00)
                $display("FAIL block_wait_%0d: got %b %b expected 001 00", i, seen, cmd_req);
            else passed++;
        end
        pulse_dv(seen);
        wait_grant(ok);
        total++;
        if (!ok || cmd_req !== 2'b10 || cmd_addr !== 26'h2ABCDE8)
            $display("FAIL block_read_after: got %b %h expected 10 2abcde8", cmd_req, cmd_addr);
        else passed++;
        ack_now();
        pc[1] = 2'b00;
        total++;
        if (ack_o !== 3'b010) $display("FAIL block_ack1: got %b expected 010", ack_o);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            pulse_dv(seen);
            total++;
            if (seen !== 3'b010) $display("FAIL block_dvalid1_%0d: got %b expected 010", i, seen);
            else passed++;
        end
        last_m = 1;
    endtask

    task automatic test_rd_err();
        logic [2:0] seen;
        pulse_dv(seen);
        total++;
        if (seen !== 3'b000 || rd_err !== 1'b1)
            $display("FAIL stray_dvalid: got %b %b expected 000 1", seen, rd_err);
        else passed++;
        repeat (5) @(posedge clk); #1;
        total++;
        if (rd_err !== 1'b1) $display("FAIL rd_err_sticky: got %b expected 1", rd_err);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        pc[0] = 2'b01; pm[0] = 2'b01; pa[0] = 26'h0000777; pd[0] = 16'h7777;
        wait_grant(ok);
        total++;
        if (!ok || cmd_req !== 2'b01) $display("FAIL mid_pre_grant: got %b expected 01", cmd_req);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if ({cmd_req, cmd_mask, cmd_addr, cmd_din, ack_o, dvalid_o, rd_err} !== '0)
            $display("FAIL mid_reset_outputs: got %h expected 0",
                     {cmd_req, cmd_mask, cmd_addr, cmd_din, ack_o, dvalid_o, rd_err});
        else passed++;
        cmd_ack = 1'b1;
        @(posedge clk); #1;
        cmd_ack = 1'b0;
        total++;
        if (ack_o !== 3'b000) $display("FAIL mid_no_ack: got %b expected 000", ack_o);
        else passed++;
        reset = 1'b1;
        last_m = 2; busy_m = 0;
        for (int k = 0; k < 3; k++) begin
            pc[k] = 2'b01; pa[k] = 26'(32'h0000010 + k); pd[k] = 16'(k);
        end
        wait_grant(ok);
        total++;
        if (!ok || cmd_addr !== 26'h0000010)
            $display("FAIL mid_port0_first: got %h expected 0000010", cmd_addr);
        else passed++;
        ack_now();
        clear_ports();
        last_m = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit ok;
        int exp_k;
        int d;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) begin
                pc[k] = 2'($urandom_range(0, 3)); pm[k] = 2'($urandom);
                pa[k] = 26'($urandom);            pd[k] = 16'($urandom);
            end
            exp_k = predict(last_m, busy_m);
            if (exp_k < 0) begin
                repeat (4) @(posedge clk); #1;
                total++;
                if (cmd_req !== 2'b00) $display("FAIL rand_nogrant_%0d: got %b expected 00", n, cmd_req);
                else passed++;
                clear_ports();
            end else begin
                wait_grant(ok);
                total++;
                if (!ok || {cmd_req, cmd_mask, cmd_addr, cmd_din} !==
                           {pc[exp_k], pm[exp_k], exp_addr(exp_k), pd[exp_k]})
                    $display("FAIL rand_cmd_%0d: got %b %b %h %h expected %b %b %h %h", n,
                             cmd_req, cmd_mask, cmd_addr, cmd_din,
                             pc[exp_k], pm[exp_k], exp_addr(exp_k), pd[exp_k]);
                else passed++;
                d = int'($urandom_range(0, 2));
                repeat (d) begin @(posedge clk); #1; end
                ack_now();
                total++;
                if (ack_o !== 3'(1 << exp_k))
                    $display("FAIL rand_ack_%0d: got %b expected %b", n, ack_o, 3'(1 << exp_k));
                else passed++;
                last_m = exp_k;
                if (pc[exp_k] == 2'b10) begin
                    busy_m = 1; rd_owner_m = exp_k; rd_left_m = 4;
                end
                clear_ports();
            end
            if (busy_m && $urandom_range(0, 1) == 1) begin
                data_valid = 1'b1;
                #1;
                total++;
                if (dvalid_o !== 3'(1 << rd_owner_m))
                    $display("FAIL rand_dvalid_%0d: got %b expected %b", n, dvalid_o, 3'(1 << rd_owner_m));
                else passed++;
                @(posedge clk); #1 data_valid = 1'b0;
                rd_left_m--;
                if (rd_left_m == 0) busy_m = 0;
            end else begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (rd_err !== 1'b0) $display("FAIL rand_rd_err: got %b expected 0", rd_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_read_block();
        test_rd_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
